// File: rtl/pulso_tecla.sv
// pulso_tecla: turns a debounced button level into single-cycle command pulses,
// with optional auto-repeat after a hold delay.
module pulso_tecla #(
  parameter int DELAY = 50000000,
  parameter int RATE  = 10000000,
  parameter int CW    = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic db,
  input  logic en_repeat,
  output logic pulse,
  output logic held,
  output logic rep_act
);
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;
  logic          held_q, held_d;
  logic          rep_act_q, rep_act_d;
  logic          hold_exp, rep_exp;
  assign hold_exp = cnt_q == CW'(DELAY - 1);
  assign rep_exp  = cnt_q == CW'(RATE - 1);
  // Release beats enable-drop, which beats counter expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (db) begin
          state_d = HOLD;
          pulse_d = 1'b1;
        end
      end
      HOLD: begin
        if (!db) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!en_repeat) begin
          cnt_d = '0;
        end else if (hold_exp) begin
          state_d = REPEAT;
          pulse_d = 1'b1;
          cnt_d   = '0;
        end
      end
      REPEAT: begin
        if (!db) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!en_repeat) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (rep_exp) begin
          pulse_d = 1'b1;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    held_d    = state_d != IDLE;
    rep_act_d = state_d == REPEAT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
      held_q    <= 1'b0;
      rep_act_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pulse_q   <= pulse_d;
      held_q    <= held_d;
      rep_act_q <= rep_act_d;
    end
  end
  assign pulse   = pulse_q;
  assign held    = held_q;
  assign rep_act = rep_act_q;
endmodule

// File: tb/tb_pulso_tecla.sv
// tb_pulso_tecla: directed scenarios with DELAY=8, RATE=4; expected {pulse,held,rep_act}
// for each edge is queued when inputs are driven and checked just after the edge.
module tb_pulso_tecla;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic db = 1'b0;
  logic en_repeat = 1'b0;
  logic pulse, held, rep_act;
  int n_cmp = 0;
  int n_err = 0;
  logic [2:0] sb[$];
  pulso_tecla #(.DELAY(8), .RATE(4), .CW(4)) dut (
    .clk(clk), .reset(reset), .db(db), .en_repeat(en_repeat),
    .pulse(pulse), .held(held), .rep_act(rep_act)
  );
  always #5 clk = ~clk;
  task automatic step(input string tag, input int k, input logic r, input logic d,
                      input logic e, input logic p, input logic h, input logic ra);
    logic [2:0] got, want;
    reset = r;
    db = d;
    en_repeat = e;
    sb.push_back({p, h, ra});
    @(posedge clk);
    #1;
    got  = {pulse, held, rep_act};
    want = sb.pop_front();
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s[%0d]: pulse/held/rep_act got %b expected %b", tag, k, got, want);
    end
  endtask
  function automatic logic rep_pulse(input int k, input int first);
    return k >= first && (k - first) % 4 == 0;
  endfunction
  initial begin
    for (int k = 1; k <= 3; k++) step("reset", k, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) step("short", k, 0, 1, 1, k == 1, 1, 0);
    for (int k = 6; k <= 8; k++) step("short_rel", k, 0, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 30; k++)
      step("long_rep", k, 0, 1, 1, k == 1 || rep_pulse(k, 9), 1, k >= 9);
    step("long_rep_rel", 31, 0, 0, 1, 0, 0, 0);
    step("idle", 32, 0, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 30; k++) step("long_norep", k, 0, 1, 0, k == 1, 1, 0);
    step("long_norep_rel", 31, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) step("rel_exp", k, 0, 1, 1, k == 1, 1, 0);
    step("rel_exp", 9, 0, 0, 1, 0, 0, 0);
    step("rel_exp", 10, 0, 0, 1, 0, 0, 0);
    step("rel_exp_new", 1, 0, 1, 1, 1, 1, 0);
    step("rel_exp_new", 2, 0, 1, 1, 0, 1, 0);
    step("rel_exp_new", 3, 0, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 15; k++)
      step("en_tog", k, 0, 1, 1, k == 1 || rep_pulse(k, 9), 1, k >= 9);
    for (int k = 16; k <= 19; k++) step("en_tog_off", k, 0, 1, 0, 0, 1, 0);
    for (int k = 20; k <= 32; k++)
      step("en_tog_on", k, 0, 1, 1, rep_pulse(k, 27), 1, k >= 27);
    step("en_tog_rel", 33, 0, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 11; k++)
      step("rst_mid", k, 0, 1, 1, k == 1 || k == 9, 1, k >= 9);
    step("rst_mid_rst", 12, 1, 1, 1, 0, 0, 0);
    step("rst_mid_rst", 13, 1, 1, 1, 0, 0, 0);
    for (int k = 1; k <= 14; k++)
      step("rst_after", k, 0, 1, 1, k == 1 || rep_pulse(k, 9), 1, k >= 9);
    step("rst_after_rel", 15, 0, 0, 1, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
